generate_graphic_pipe: RTL and testbench

- Pipelined, parametrised pixel generator between the VGA timing controller and the data-memory read port.
- Converts the current beam position (x, y) into a frame-buffer word address and issues a read.
- Aligns the returned 32-bit word with delayed sync/blank signals.
- Produces RGB888 from one of three modes (direct, grayscale, test pattern) with integer upscaling and a configurable background colour.

---
 rtl/graphic_pkg.sv | 30 +++
 rtl/graphic_delay_line.sv | 28 ++
 rtl/generate_graphic_pipe.sv | 126 ++++++++++++
 tb/tb_generate_graphic_pipe.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/graphic_pkg.sv
// Shared types and constants for the pixel pipeline: mode encoding, colour-bar palette, luma weights.
// Pure declarations and combinational helpers; no timing or flow control.
package graphic_pkg;

   typedef enum logic [1:0] {
      MODE_DIRECT = 2'd0,
      MODE_GRAY   = 2'd1,
      MODE_BARS   = 2'd2
   } mode_t;

   localparam int GRAY_R = 77;
   localparam int GRAY_G = 150;
   localparam int GRAY_B = 29;

   // Left to right: white, yellow, cyan, green, magenta, red, blue, black
   localparam logic [23:0] BAR_RGB [8] = '{
      24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
      24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
   };

   // The reserved encoding falls back to direct colour
   function automatic mode_t decode_mode(input logic [1:0] m);
      return (m == 2'd3) ? MODE_DIRECT : mode_t'(m);
   endfunction

   function automatic logic in_range(input int v, input int lo, input int hi);
      return (v >= lo) && (v < hi);
   endfunction

endpackage

// File: rtl/graphic_delay_line.sv
// Enabled shift register of DEPTH stages, W bits wide, loading RST_VAL on reset.
// Latency DEPTH enabled cycles; holds all stages while en is low.
module graphic_delay_line #(
   parameter int           W       = 1,
   parameter int           DEPTH   = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] sr [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) sr[i] <= RST_VAL;
      end else if (en) begin
         sr[0] <= d;
         for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
   end

   assign q = sr[DEPTH-1];

endmodule

// File: rtl/generate_graphic_pipe.sv
// Beam position -> frame-buffer read -> RGB888 with delayed syncs; latency MEM_LAT+2 enabled cycles.
// Advances only on pix_en; no backpressure, memory must answer exactly MEM_LAT enabled cycles after mem_rd.
module generate_graphic_pipe
   import graphic_pkg::*;
#(
   parameter int          X_W       = 10,
   parameter int          IMG_X0    = 120,
   parameter int          IMG_Y0    = 0,
   parameter int          IMG_W     = 160,
   parameter int          IMG_H     = 100,
   parameter int          SCALE_SH  = 1,
   parameter int          ADDR_W    = 16,
   parameter int          BASE_ADDR = 0,
   parameter int          MEM_LAT   = 1,
   parameter logic [23:0] BG_RGB    = 24'h555555
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pix_en,
   input  logic [X_W-1:0]    x,
   input  logic [X_W-1:0]    y,
   input  logic              hsync_i,
   input  logic              vsync_i,
   input  logic              blank_i,
   input  logic [1:0]        mode,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [31:0]       ReadData,
   output logic [7:0]        red,
   output logic [7:0]        green,
   output logic [7:0]        blue,
   output logic              hsync_o,
   output logic              vsync_o,
   output logic              blank_o
);

   localparam int X_END = IMG_X0 + (IMG_W << SCALE_SH);
   localparam int Y_END = IMG_Y0 + (IMG_H << SCALE_SH);

   typedef struct packed {
      logic       in_win;
      logic [2:0] bar;
      logic       hsync;
      logic       vsync;
      logic       blank;
   } side_t;

   localparam side_t SIDE_RST = '{in_win: 1'b0, bar: 3'd0, hsync: 1'b1, vsync: 1'b1, blank: 1'b1};

   logic              in_win;
   logic [X_W-1:0]    col;
   logic [X_W-1:0]    row;
   logic [ADDR_W-1:0] addr_next;
   logic [2:0]        bar_next;
   side_t             side_next;
   side_t             side_q;
   logic              vs_prev;
   mode_t             mode_q;
   logic [7:0]        luma;
   logic [23:0]       rgb_next;
   logic              unused_hi;

   // Range tests on the raw coordinates come first so x < IMG_X0 never wraps into the window
   assign in_win = in_range(int'(x), IMG_X0, X_END) && (x != '1) &&
                   in_range(int'(y), IMG_Y0, Y_END) && (y != '1) && !blank_i;

   assign col       = X_W'((int'(x) - IMG_X0) >> SCALE_SH);
   assign row       = X_W'((int'(y) - IMG_Y0) >> SCALE_SH);
   assign addr_next = ADDR_W'(BASE_ADDR + int'(row) * IMG_W + int'(col));
   assign bar_next  = 3'((int'(col) * 8) / IMG_W);
   assign side_next = '{in_win: in_win, bar: bar_next, hsync: hsync_i, vsync: vsync_i, blank: blank_i};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_rd   <= 1'b0;
         mem_addr <= ADDR_W'(BASE_ADDR);
         vs_prev  <= 1'b1;
         mode_q   <= MODE_DIRECT;
      end else if (pix_en) begin
         mem_rd  <= in_win;
         if (in_win) mem_addr <= addr_next;
         vs_prev <= vsync_i;
         if (vs_prev && !vsync_i) mode_q <= decode_mode(mode);
      end
   end

   graphic_delay_line #(
      .W       ($bits(side_t)),
      .DEPTH   (MEM_LAT + 1),
      .RST_VAL (SIDE_RST)
   ) u_side_dly (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (pix_en),
      .d     (side_next),
      .q     (side_q)
   );

   assign unused_hi = ^ReadData[31:24];
   assign luma = 8'((int'(ReadData[23:16]) * GRAY_R + int'(ReadData[15:8]) * GRAY_G +
                     int'(ReadData[7:0]) * GRAY_B) >> 8);

   always_comb begin
      rgb_next = BG_RGB;
      if (side_q.blank) begin
         rgb_next = 24'h000000;
      end else if (side_q.in_win) begin
         case (mode_q)
            MODE_GRAY: rgb_next = {3{luma}};
            MODE_BARS: rgb_next = BAR_RGB[side_q.bar];
            default:   rgb_next = ReadData[23:0];
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {red, green, blue}          <= 24'h000000;
         {hsync_o, vsync_o, blank_o} <= 3'b111;
      end else if (pix_en) begin
         {red, green, blue}          <= rgb_next;
         {hsync_o, vsync_o, blank_o} <= {side_q.hsync, side_q.vsync, side_q.blank};
      end
   end

endmodule

// File: tb/tb_generate_graphic_pipe.sv
// Drives two pipelines (MEM_LAT=1 and MEM_LAT=2) with directed and random beam positions and
// compares both against a frame-level model of the window, modes and latency.
module tb_generate_graphic_pipe;

   localparam int L1 = 3;
   localparam int L2 = 4;

   logic        clk = 1'b0;
   logic        rst_n, pix_en, hsync_i, vsync_i, blank_i;
   logic [9:0]  x, y;
   logic [1:0]  mode;
   logic [15:0] addr1, addr2;
   logic        rd1, rd2;
   logic [31:0] rdata1, rdata2;
   logic [7:0]  r1, g1, b1, r2, g2, b2;
   logic        hs1, vs1, bl1, hs2, vs2, bl2;

   always #5 clk = ~clk;

   logic [31:0] mem [65536];
   logic [15:0] p1  = '0;
   logic [15:0] p2a = '0;
   logic [15:0] p2b = '0;

   always @(posedge clk) if (pix_en) begin
      p1  <= addr1;
      p2a <= addr2;
      p2b <= p2a;
   end
   assign rdata1 = mem[p1];
   assign rdata2 = mem[p2b];

   generate_graphic_pipe #(.MEM_LAT(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .x(x), .y(y),
      .hsync_i(hsync_i), .vsync_i(vsync_i), .blank_i(blank_i), .mode(mode),
      .mem_addr(addr1), .mem_rd(rd1), .ReadData(rdata1),
      .red(r1), .green(g1), .blue(b1), .hsync_o(hs1), .vsync_o(vs1), .blank_o(bl1));

   generate_graphic_pipe #(.MEM_LAT(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .x(x), .y(y),
      .hsync_i(hsync_i), .vsync_i(vsync_i), .blank_i(blank_i), .mode(mode),
      .mem_addr(addr2), .mem_rd(rd2), .ReadData(rdata2),
      .red(r2), .green(g2), .blue(b2), .hsync_o(hs2), .vsync_o(vs2), .blank_o(bl2));

   typedef struct packed {
      logic [23:0] rgb;
      logic [2:0]  syn;
   } out_t;

   localparam out_t OUT_RST = '{rgb: 24'h0, syn: 3'b111};

   out_t        q_exp[$];
   int          m_mode;
   logic        m_vs_prev;
   logic        e_rd;
   logic [15:0] e_addr;
   int          n_cmp = 0;
   int          n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic model_inwin(input int xx, input int yy, input logic bl);
      return !bl && xx >= 120 && xx < 440 && yy >= 0 && yy < 200;
   endfunction

   function automatic logic [23:0] model_rgb(input int xx, input int yy, input logic bl, input int md);
      int col, lum;
      logic [31:0] w;
      if (bl) return 24'h000000;
      if (!model_inwin(xx, yy, bl)) return 24'h555555;
      col = (xx - 120) / 2;
      w   = mem[((yy / 2) * 160 + col) % 65536];
      if (md == 1) begin
         lum = (int'(w[23:16]) * 77 + int'(w[15:8]) * 150 + int'(w[7:0]) * 29) / 256;
         return {3{lum[7:0]}};
      end
      if (md == 2) begin
         case (col * 8 / 160)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
         endcase
      end
      return w[23:0];
   endfunction

   task automatic model_reset();
      q_exp.delete();
      m_mode    = 0;
      m_vs_prev = 1'b1;
      e_rd      = 1'b0;
      e_addr    = '0;
   endtask

   task automatic model_edge();
      out_t o;
      if (m_vs_prev && !vsync_i) m_mode = (mode == 2'd3) ? 0 : int'(mode);
      m_vs_prev = vsync_i;
      o.rgb = model_rgb(int'(x), int'(y), blank_i, m_mode);
      o.syn = {hsync_i, vsync_i, blank_i};
      q_exp.push_back(o);
      if (q_exp.size() > 8) void'(q_exp.pop_front());
      e_rd = model_inwin(int'(x), int'(y), blank_i);
      if (e_rd) e_addr = 16'(((int'(y) / 2) * 160 + (int'(x) - 120) / 2) % 65536);
   endtask

   function automatic out_t exp_out(input int lat);
      if (q_exp.size() >= lat) return q_exp[q_exp.size() - lat];
      return OUT_RST;
   endfunction

   task automatic check_all();
      out_t e1, e2;
      e1 = exp_out(L1);
      e2 = exp_out(L2);
      chk("rgb_lat1", {8'h0, r1, g1, b1}, {8'h0, e1.rgb});
      chk("syn_lat1", {29'h0, hs1, vs1, bl1}, {29'h0, e1.syn});
      chk("rgb_lat2", {8'h0, r2, g2, b2}, {8'h0, e2.rgb});
      chk("syn_lat2", {29'h0, hs2, vs2, bl2}, {29'h0, e2.syn});
      chk("mem_rd1", 32'(rd1), 32'(e_rd));
      chk("mem_rd2", 32'(rd2), 32'(e_rd));
      if (e_rd) begin
         chk("mem_addr1", 32'(addr1), 32'(e_addr));
         chk("mem_addr2", 32'(addr2), 32'(e_addr));
      end
   endtask

   task automatic chk_reset();
      chk("rst_rgb1", {8'h0, r1, g1, b1}, 32'h0);
      chk("rst_rgb2", {8'h0, r2, g2, b2}, 32'h0);
      chk("rst_syn1", {29'h0, hs1, vs1, bl1}, 32'h7);
      chk("rst_syn2", {29'h0, hs2, vs2, bl2}, 32'h7);
      chk("rst_rd1", 32'(rd1), 32'h0);
      chk("rst_rd2", 32'(rd2), 32'h0);
      chk("rst_addr1", 32'(addr1), 32'h0);
   endtask

   task automatic step(input logic en);
      pix_en = en;
      @(posedge clk);
      if (en) model_edge();
      #1;
      check_all();
   endtask

   task automatic pix(input int xx, input int yy);
      x       = 10'(xx);
      y       = 10'(yy);
      blank_i = 1'b0;
      step(1'b1);
   endtask

   task automatic frame_start(input logic [1:0] m);
      mode    = m;
      blank_i = 1'b1;
      hsync_i = 1'b1;
      x       = '0;
      y       = '0;
      repeat (4) step(1'b1);
      vsync_i = 1'b0;
      repeat (2) step(1'b1);
      vsync_i = 1'b1;
      repeat (4) step(1'b1);
   endtask

   initial begin
      for (int a = 0; a < 16000; a++) mem[a] = $urandom;
      mem[0] = 32'h00AA3311;
      mem[1] = 32'h00FF0000;
      mem[2] = 32'h00FFFFFF;

      rst_n = 1'b0; pix_en = 1'b0; x = '0; y = '0;
      hsync_i = 1'b1; vsync_i = 1'b1; blank_i = 1'b1; mode = 2'd0;
      model_reset();
      repeat (6) begin
         pix_en = ~pix_en;
         @(posedge clk);
         #1;
         chk_reset();
      end
      rst_n = 1'b1;

      frame_start(2'd0);
      pix(120, 0);
      chk("addr_origin", 32'(addr1), 32'd0);
      chk("rd_origin", 32'(rd1), 32'd1);
      pix(123, 5);
      chk("addr_123_5", 32'(addr1), 32'd321);
      pix(440, 0);
      chk("direct_lat1", {8'h0, r1, g1, b1}, 32'h00AA3311);
      pix(119, 0);
      chk("direct_lat2", {8'h0, r2, g2, b2}, 32'h00AA3311);

      pix(439, 199);
      chk("addr_corner", 32'(addr1), 32'd15999);
      chk("rd_corner", 32'(rd1), 32'd1);
      pix(440, 199);
      chk("rd_right_out", 32'(rd1), 32'd0);
      pix(119, 199);
      chk("rd_left_out", 32'(rd1), 32'd0);
      pix(1023, 1023);
      chk("bg_right", {8'h0, r1, g1, b1}, 32'h00555555);
      pix(439, 200);
      chk("bg_left", {8'h0, r1, g1, b1}, 32'h00555555);
      pix(120, 199);

      frame_start(2'd1);
      pix(122, 0);
      pix(124, 0);
      pix(440, 0);
      chk("gray_red", {8'h0, r1, g1, b1}, 32'h004C4C4C);
      pix(440, 0);
      chk("gray_white", {8'h0, r1, g1, b1}, 32'h00FFFFFF);

      frame_start(2'd0);
      mode = 2'd2;
      pix(120, 0);
      pix(121, 0);
      pix(440, 0);
      chk("midframe_direct", {8'h0, r1, g1, b1}, 32'h00AA3311);
      frame_start(2'd2);
      pix(120, 0);
      pix(439, 0);
      pix(440, 0);
      chk("bars_white", {8'h0, r1, g1, b1}, 32'h00FFFFFF);
      pix(440, 0);
      chk("bars_black", {8'h0, r1, g1, b1}, 32'h00000000);

      for (int f = 0; f < 6; f++) begin
         frame_start(2'($urandom_range(0, 3)));
         for (int i = 0; i < 120; i++) begin
            x = 10'($urandom_range(100, 460));
            y = 10'($urandom_range(0, 215));
            if ($urandom_range(0, 15) == 0) x = 10'h3FF;
            blank_i = ($urandom_range(0, 7) == 0);
            hsync_i = 1'($urandom_range(0, 1));
            if (f == 3 && i == 60) begin
               rst_n = 1'b0;
               #1;
               chk_reset();
               model_reset();
               @(posedge clk);
               #1;
               rst_n = 1'b1;
            end
            if (f % 2 == 0) step(i % 4 == 0);
            else step(1'($urandom_range(0, 1)));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
